// File: rtl/bomb_pkg.sv
// bomb_pkg: shared encodings and widths for the bomb scheduler.
// Holds the slot state encoding, coordinate/counter widths, the chain
// distance, and the chain proximity helper used when BOMB_CHAIN_EN is defined.
package bomb_pkg;
  localparam int COORD_W = 10;
  localparam int CNT_W = 8;
  localparam int CHAIN_DIST = 64;
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FUSE  = 2'd1,
    S_BLAST = 2'd2
  } slot_state_t;
  function automatic logic [COORD_W-1:0] abs_diff(input logic [COORD_W-1:0] a, b);
    return (a > b) ? a - b : b - a;
  endfunction
  // Two bombs chain when they share a column or row and sit within
  // CHAIN_DIST pixels of each other along the other axis.
  function automatic logic chain_near(input logic [COORD_W-1:0] ax, ay, bx, by);
    return (ax == bx && abs_diff(ay, by) <= COORD_W'(CHAIN_DIST)) ||
           (ay == by && abs_diff(ax, bx) <= COORD_W'(CHAIN_DIST));
  endfunction
endpackage

// File: rtl/bomb_slot.sv
// bomb_slot: one bomb slot, IDLE -> FUSE -> BLAST -> IDLE with a tick down-counter.
// Ports:
//   clk, reset      clock, asynchronous active-low reset
//   clear           synchronous clear to IDLE (round restart), beats everything else
//   tick            game-tick strobe
//   alloc           load a new bomb (only asserted while IDLE)
//   owner_in, x_in, y_in   owner and coordinates latched on alloc
//   chain           neighbour entered BLAST; blast on the next tick (BOMB_CHAIN_EN only)
//   fuse, blast     state flags
//   owner, x, y     latched bomb data (held after the bomb expires)
//   enter_blast     combinational: this slot moves to BLAST at the coming edge
// Optional feature macro: BOMB_CHAIN_EN.
module bomb_slot
  import bomb_pkg::*;
#(
  parameter int FUSE_TICKS  = 48,
  parameter int BLAST_TICKS = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               tick,
  input  logic               alloc,
  input  logic               owner_in,
  input  logic [COORD_W-1:0] x_in,
  input  logic [COORD_W-1:0] y_in,
  input  logic               chain,
  output logic               fuse,
  output logic               blast,
  output logic               owner,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               enter_blast
);
  slot_state_t state;
  logic [CNT_W-1:0] cnt;
  logic chain_pend;
  assign fuse = state == S_FUSE;
  assign blast = state == S_BLAST;
  assign enter_blast = !clear && tick && fuse && (cnt == CNT_W'(1) || chain_pend);
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= S_IDLE;
      cnt <= '0;
      owner <= 1'b0;
      x <= '0;
      y <= '0;
    end else if (clear) begin
      state <= S_IDLE;
      cnt <= '0;
    end else if (alloc) begin
      state <= S_FUSE;
      cnt <= CNT_W'(FUSE_TICKS);
      owner <= owner_in;
      x <= x_in;
      y <= y_in;
    end else if (enter_blast) begin
      state <= S_BLAST;
      cnt <= CNT_W'(BLAST_TICKS);
    end else if (tick && state != S_IDLE) begin
      state <= (blast && cnt == CNT_W'(1)) ? S_IDLE : state;
      cnt <= cnt - CNT_W'(1);
    end
`ifdef BOMB_CHAIN_EN
  // A chain hit is remembered until the next tick so the blast propagates
  // one tick per hop rather than in the same cycle.
  always_ff @(posedge clk or negedge reset)
    if (!reset)
      chain_pend <= 1'b0;
    else
      chain_pend <= !clear && !alloc && fuse && !enter_blast && (chain_pend || chain);
`else
  logic unused_chain;
  assign unused_chain = chain;
  assign chain_pend = 1'b0;
`endif
endmodule

// File: rtl/bomb_scheduler.sv
// bomb_scheduler: two-player bomb placement arbiter over NUM_SLOTS bomb slots.
// Ports:
//   clk, reset                   clock, asynchronous active-low reset
//   tick                         game-tick strobe
//   round_restart                synchronous clear of all slots and pending responses
//   p1_req/p2_req, p*_x/p*_y     placement requests with pixel coordinates
//   p1_ack/p1_nack/p2_ack/p2_nack  one-cycle responses, one cycle after sampling
//   bomb_fuse/bomb_blast/bomb_owner  per-slot flags, owner 0=P1 1=P2
//   bomb_x/bomb_y                flattened per-slot coordinates, slot 0 in LSBs
//   blast_pulse, blast_slot      pulse when a slot enters BLAST, lowest such index
// Optional feature macro: BOMB_CHAIN_EN (blasts chain into aligned nearby fuses).
module bomb_scheduler
  import bomb_pkg::*;
#(
  parameter int NUM_SLOTS      = 4,
  parameter int FUSE_TICKS     = 48,
  parameter int BLAST_TICKS    = 16,
  parameter int MAX_PER_PLAYER = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         tick,
  input  logic                         round_restart,
  input  logic                         p1_req,
  input  logic                         p2_req,
  input  logic [COORD_W-1:0]           p1_x,
  input  logic [COORD_W-1:0]           p1_y,
  input  logic [COORD_W-1:0]           p2_x,
  input  logic [COORD_W-1:0]           p2_y,
  output logic                         p1_ack,
  output logic                         p1_nack,
  output logic                         p2_ack,
  output logic                         p2_nack,
  output logic [NUM_SLOTS-1:0]         bomb_fuse,
  output logic [NUM_SLOTS-1:0]         bomb_blast,
  output logic [NUM_SLOTS-1:0]         bomb_owner,
  output logic [COORD_W*NUM_SLOTS-1:0] bomb_x,
  output logic [COORD_W*NUM_SLOTS-1:0] bomb_y,
  output logic                         blast_pulse,
  output logic [2:0]                   blast_slot
);
  logic [NUM_SLOTS-1:0] idle, enter, alloc, chain;
  logic [3:0] p1_live, p2_live, serve_live;
  logic [2:0] free_idx, enter_idx;
  logic rr_p2, p1_elig, p2_elig, serve, serve_p2, grant;
  logic [COORD_W-1:0] gx, gy;
  assign idle = ~(bomb_fuse | bomb_blast);
  // Live counts come straight from slot state so they can never drift.
  always_comb begin
    p1_live = '0;
    p2_live = '0;
    free_idx = '0;
    enter_idx = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      p1_live = p1_live + 4'(!idle[i] && !bomb_owner[i]);
      p2_live = p2_live + 4'(!idle[i] && bomb_owner[i]);
      if (idle[i]) free_idx = 3'(i);
      if (enter[i]) enter_idx = 3'(i);
    end
  end
  // A player whose response is pulsing this cycle is not re-sampled.
  assign p1_elig = p1_req && !p1_ack && !p1_nack && !round_restart;
  assign p2_elig = p2_req && !p2_ack && !p2_nack && !round_restart;
  assign serve = p1_elig || p2_elig;
  assign serve_p2 = p2_elig && (!p1_elig || rr_p2);
  assign serve_live = serve_p2 ? p2_live : p1_live;
  assign grant = serve && |idle && int'(serve_live) < MAX_PER_PLAYER;
  assign alloc = grant ? (NUM_SLOTS'(1) << free_idx) : '0;
  assign gx = serve_p2 ? p2_x : p1_x;
  assign gy = serve_p2 ? p2_y : p1_y;
  // Priority flips only when both players contend in the same cycle.
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      p1_ack <= 1'b0;
      p1_nack <= 1'b0;
      p2_ack <= 1'b0;
      p2_nack <= 1'b0;
      rr_p2 <= 1'b0;
      blast_pulse <= 1'b0;
      blast_slot <= '0;
    end else begin
      p1_ack <= serve && !serve_p2 && grant;
      p1_nack <= serve && !serve_p2 && !grant;
      p2_ack <= serve_p2 && grant;
      p2_nack <= serve_p2 && !grant;
      rr_p2 <= round_restart ? 1'b0 : (p1_elig && p2_elig) ? !rr_p2 : rr_p2;
      blast_pulse <= |enter;
      blast_slot <= enter_idx;
    end
  for (genvar g = 0; g < NUM_SLOTS; g++) begin : s
    bomb_slot #(
      .FUSE_TICKS (FUSE_TICKS),
      .BLAST_TICKS(BLAST_TICKS)
    ) u_slot (
      .clk        (clk),
      .reset      (reset),
      .clear      (round_restart),
      .tick       (tick),
      .alloc      (alloc[g]),
      .owner_in   (serve_p2),
      .x_in       (gx),
      .y_in       (gy),
      .chain      (chain[g]),
      .fuse       (bomb_fuse[g]),
      .blast      (bomb_blast[g]),
      .owner      (bomb_owner[g]),
      .x          (bomb_x[g*COORD_W +: COORD_W]),
      .y          (bomb_y[g*COORD_W +: COORD_W]),
      .enter_blast(enter[g])
    );
  end
`ifdef BOMB_CHAIN_EN
  always_comb begin
    chain = '0;
    for (int i = 0; i < NUM_SLOTS; i++)
      for (int j = 0; j < NUM_SLOTS; j++)
        if (i != j && enter[j] && bomb_fuse[i] &&
            chain_near(bomb_x[i*COORD_W +: COORD_W], bomb_y[i*COORD_W +: COORD_W],
                       bomb_x[j*COORD_W +: COORD_W], bomb_y[j*COORD_W +: COORD_W]))
          chain[i] = 1'b1;
  end
`else
  assign chain = '0;
`endif
endmodule

// File: tb/tb_bomb_scheduler.sv
// tb_bomb_scheduler: self-checking bench for bomb_scheduler with a timeline reference model.
module tb_bomb_scheduler;
  localparam int NS = 4;
  localparam int FT = 48;
  localparam int BT = 16;
  localparam int MP = 2;
  logic clk = 0, reset = 1, tick = 0, round_restart = 0, p1_req = 0, p2_req = 0;
  logic [9:0] p1_x = 0, p1_y = 0, p2_x = 0, p2_y = 0;
  logic p1_ack, p1_nack, p2_ack, p2_nack, blast_pulse;
  logic [NS-1:0] bomb_fuse, bomb_blast, bomb_owner;
  logic [10*NS-1:0] bomb_x, bomb_y;
  logic [2:0] blast_slot;
  int compared = 0, mismatched = 0;
  int gt = 0;
  bit used[NS];
  int placed[NS];
  int owner_m[NS];
  always #5 clk = ~clk;
  bomb_scheduler #(
    .NUM_SLOTS(NS), .FUSE_TICKS(FT), .BLAST_TICKS(BT), .MAX_PER_PLAYER(MP)
  ) dut (
    .clk(clk), .reset(reset), .tick(tick), .round_restart(round_restart),
    .p1_req(p1_req), .p2_req(p2_req), .p1_x(p1_x), .p1_y(p1_y), .p2_x(p2_x), .p2_y(p2_y),
    .p1_ack(p1_ack), .p1_nack(p1_nack), .p2_ack(p2_ack), .p2_nack(p2_nack),
    .bomb_fuse(bomb_fuse), .bomb_blast(bomb_blast), .bomb_owner(bomb_owner),
    .bomb_x(bomb_x), .bomb_y(bomb_y), .blast_pulse(blast_pulse), .blast_slot(blast_slot)
  );
  // Reference: a bomb's phase follows purely from ticks elapsed since placement.
  function automatic int mstate(input int i);
    int e;
    if (!used[i]) return 0;
    e = gt - placed[i];
    return (e < FT) ? 1 : (e < FT + BT) ? 2 : 0;
  endfunction
  task automatic cyc(input logic t);
    tick = t;
    @(posedge clk);
    #1;
    tick = 0;
    if (t) gt++;
  endtask
  task automatic request(input int p, input logic [9:0] x, input logic [9:0] y);
    if (p1_ack || p1_nack || p2_ack || p2_nack) cyc(0);
    if (p == 1) begin p1_x = x; p1_y = y; p1_req = 1; end
    else begin p2_x = x; p2_y = y; p2_req = 1; end
    cyc(0);
    p1_req = 0;
    p2_req = 0;
  endtask
  task automatic restart;
    round_restart = 1;
    cyc(0);
    round_restart = 0;
  endtask
  task automatic test_reset;
    #2 reset = 0;
    #3;
    compared++; if ({p1_ack, p1_nack, p2_ack, p2_nack, blast_pulse} !== 5'b0) begin mismatched++; $display("FAIL reset_pulses got=%b exp=00000", {p1_ack, p1_nack, p2_ack, p2_nack, blast_pulse}); end
    compared++; if ({bomb_fuse, bomb_blast} !== '0) begin mismatched++; $display("FAIL reset_state got=%b exp=0", {bomb_fuse, bomb_blast}); end
    compared++; if ({bomb_x, bomb_y} !== '0) begin mismatched++; $display("FAIL reset_coords got=%h exp=0", {bomb_x, bomb_y}); end
    @(posedge clk);
    #1 reset = 1;
    cyc(0);
  endtask
  task automatic test_single;
    request(1, 100, 240);
    compared++; if ({p1_ack, p1_nack, p2_ack, p2_nack} !== 4'b1000) begin mismatched++; $display("FAIL single_ack got=%b exp=1000", {p1_ack, p1_nack, p2_ack, p2_nack}); end
    compared++; if (bomb_fuse !== 4'b0001 || bomb_owner[0] !== 1'b0) begin mismatched++; $display("FAIL single_fuse got=%b/%b exp=0001/0", bomb_fuse, bomb_owner[0]); end
    compared++; if (bomb_x[9:0] !== 10'd100 || bomb_y[9:0] !== 10'd240) begin mismatched++; $display("FAIL single_xy got=%0d,%0d exp=100,240", bomb_x[9:0], bomb_y[9:0]); end
    cyc(0);
    compared++; if (p1_ack !== 1'b0) begin mismatched++; $display("FAIL single_ack_width got=%b exp=0", p1_ack); end
    repeat (FT - 1) cyc(1);
    compared++; if ({bomb_fuse, bomb_blast} !== 8'b0001_0000) begin mismatched++; $display("FAIL single_fuse_47 got=%b exp=00010000", {bomb_fuse, bomb_blast}); end
    cyc(1);
    compared++; if ({bomb_fuse, bomb_blast} !== 8'b0000_0001) begin mismatched++; $display("FAIL single_blast got=%b exp=00000001", {bomb_fuse, bomb_blast}); end
    compared++; if (blast_pulse !== 1'b1 || blast_slot !== 3'd0) begin mismatched++; $display("FAIL single_pulse got=%b/%0d exp=1/0", blast_pulse, blast_slot); end
    cyc(0);
    compared++; if (blast_pulse !== 1'b0) begin mismatched++; $display("FAIL single_pulse_width got=%b exp=0", blast_pulse); end
    repeat (BT - 1) cyc(1);
    compared++; if (bomb_blast !== 4'b0001) begin mismatched++; $display("FAIL single_blast_15 got=%b exp=0001", bomb_blast); end
    cyc(1);
    compared++; if ({bomb_fuse, bomb_blast} !== 8'b0) begin mismatched++; $display("FAIL single_idle got=%b exp=0", {bomb_fuse, bomb_blast}); end
    compared++; if (bomb_x[9:0] !== 10'd100) begin mismatched++; $display("FAIL single_hold_x got=%0d exp=100", bomb_x[9:0]); end
  endtask
  task automatic test_contention;
    restart;
    p1_x = 11; p1_y = 12; p2_x = 21; p2_y = 22; p1_req = 1; p2_req = 1;
    cyc(0);
    p1_req = 0;
    compared++; if ({p1_ack, p2_ack} !== 2'b10 || bomb_fuse !== 4'b0001 || bomb_owner[0] !== 1'b0) begin mismatched++; $display("FAIL rr1_first got=%b%b/%b exp=10/0001", p1_ack, p2_ack, bomb_fuse); end
    cyc(0);
    p2_req = 0;
    compared++; if ({p1_ack, p2_ack} !== 2'b01 || bomb_fuse !== 4'b0011 || bomb_owner[1] !== 1'b1) begin mismatched++; $display("FAIL rr1_second got=%b%b/%b exp=01/0011", p1_ack, p2_ack, bomb_fuse); end
    cyc(0);
    p1_x = 31; p2_x = 41; p1_req = 1; p2_req = 1;
    cyc(0);
    p2_req = 0;
    compared++; if ({p1_ack, p2_ack} !== 2'b01 || bomb_owner[2] !== 1'b1 || bomb_x[29:20] !== 10'd41) begin mismatched++; $display("FAIL rr2_first got=%b%b/%b/%0d exp=01/1/41", p1_ack, p2_ack, bomb_owner[2], bomb_x[29:20]); end
    cyc(0);
    p1_req = 0;
    compared++; if ({p1_ack, p2_ack} !== 2'b10 || bomb_owner[3] !== 1'b0 || bomb_x[39:30] !== 10'd31) begin mismatched++; $display("FAIL rr2_second got=%b%b/%b/%0d exp=10/0/31", p1_ack, p2_ack, bomb_owner[3], bomb_x[39:30]); end
    request(2, 5, 5);
    compared++; if ({p2_ack, p2_nack} !== 2'b01 || bomb_fuse !== 4'b1111) begin mismatched++; $display("FAIL full_nack got=%b/%b exp=01/1111", {p2_ack, p2_nack}, bomb_fuse); end
  endtask
  task automatic test_limit;
    restart;
    request(1, 10, 20);
    compared++; if (p1_ack !== 1'b1 || bomb_fuse !== 4'b0001) begin mismatched++; $display("FAIL lim_p1a got=%b/%b exp=1/0001", p1_ack, bomb_fuse); end
    request(1, 30, 40);
    compared++; if (p1_ack !== 1'b1 || bomb_fuse !== 4'b0011) begin mismatched++; $display("FAIL lim_p1b got=%b/%b exp=1/0011", p1_ack, bomb_fuse); end
    request(1, 50, 60);
    compared++; if ({p1_ack, p1_nack} !== 2'b01 || bomb_fuse !== 4'b0011) begin mismatched++; $display("FAIL lim_p1_nack got=%b/%b exp=01/0011", {p1_ack, p1_nack}, bomb_fuse); end
    request(2, 70, 80);
    compared++; if (p2_ack !== 1'b1 || bomb_fuse !== 4'b0111 || bomb_owner[2] !== 1'b1) begin mismatched++; $display("FAIL lim_p2a got=%b/%b exp=1/0111", p2_ack, bomb_fuse); end
    request(2, 90, 100);
    compared++; if (p2_ack !== 1'b1 || bomb_fuse !== 4'b1111 || bomb_owner[3] !== 1'b1) begin mismatched++; $display("FAIL lim_p2b got=%b/%b exp=1/1111", p2_ack, bomb_fuse); end
    request(2, 110, 120);
    compared++; if ({p2_ack, p2_nack} !== 2'b01) begin mismatched++; $display("FAIL lim_p2_nack got=%b exp=01", {p2_ack, p2_nack}); end
  endtask
  task automatic test_free_same_cycle;
    restart;
    request(1, 1, 1);
    cyc(1);
    request(2, 2, 2);
    request(2, 3, 3);
    request(1, 4, 4);
    cyc(0);
    repeat (FT + BT - 2) cyc(1);
    compared++; if (bomb_blast !== 4'b1111) begin mismatched++; $display("FAIL free_pre got=%b exp=1111", bomb_blast); end
    p1_x = 7; p1_y = 8; p1_req = 1;
    cyc(1);
    p1_req = 0;
    compared++; if ({p1_ack, p1_nack} !== 2'b01 || bomb_blast[0] !== 1'b0 || bomb_fuse[0] !== 1'b0) begin mismatched++; $display("FAIL free_same_cycle got=%b/%b%b exp=01/00", {p1_ack, p1_nack}, bomb_fuse[0], bomb_blast[0]); end
    request(1, 7, 8);
    compared++; if (p1_ack !== 1'b1 || bomb_fuse !== 4'b0001 || bomb_x[9:0] !== 10'd7) begin mismatched++; $display("FAIL free_next got=%b/%b/%0d exp=1/0001/7", p1_ack, bomb_fuse, bomb_x[9:0]); end
  endtask
  task automatic test_restart;
    int pulses;
    p2_req = 1; round_restart = 1;
    cyc(1);
    compared++; if ({p1_ack, p1_nack, p2_ack, p2_nack, blast_pulse} !== 5'b0 || {bomb_fuse, bomb_blast} !== '0) begin mismatched++; $display("FAIL rst_clear got=%b/%b exp=0/0", {p1_ack, p1_nack, p2_ack, p2_nack, blast_pulse}, {bomb_fuse, bomb_blast}); end
    p2_req = 0; round_restart = 0;
    cyc(0);
    compared++; if ({p1_ack, p1_nack, p2_ack, p2_nack} !== 4'b0) begin mismatched++; $display("FAIL rst_no_resp got=%b exp=0000", {p1_ack, p1_nack, p2_ack, p2_nack}); end
    p1_req = 1; p2_req = 1;
    cyc(0);
    p1_req = 0;
    cyc(0);
    p2_req = 0;
    restart;
    p1_req = 1; p2_req = 1;
    cyc(0);
    p1_req = 0; p2_req = 0;
    compared++; if ({p1_ack, p2_ack} !== 2'b10) begin mismatched++; $display("FAIL rst_rr got=%b exp=10", {p1_ack, p2_ack}); end
    cyc(0);
    restart;
    request(1, 5, 5);
    repeat (10) cyc(1);
    #2 reset = 0;
    #1;
    compared++; if ({bomb_fuse, bomb_blast} !== '0 || bomb_x !== '0) begin mismatched++; $display("FAIL reset_mid_fuse got=%b/%h exp=0/0", {bomb_fuse, bomb_blast}, bomb_x); end
    @(posedge clk);
    #1 reset = 1;
    pulses = 0;
    for (int i = 0; i < FT; i++) begin cyc(1); pulses += int'(blast_pulse); end
    compared++; if (pulses !== 0) begin mismatched++; $display("FAIL reset_no_blast got=%0d exp=0", pulses); end
  endtask
  task automatic test_chain;
    restart;
    request(1, 100, 240);
    cyc(0);
    repeat (5) cyc(1);
    request(2, 140, 240);
    cyc(0);
    repeat (FT - 5) cyc(1);
    compared++; if (bomb_blast !== 4'b0001 || blast_pulse !== 1'b1 || blast_slot !== 3'd0) begin mismatched++; $display("FAIL chain_first got=%b/%b/%0d exp=0001/1/0", bomb_blast, blast_pulse, blast_slot); end
    cyc(1);
`ifdef BOMB_CHAIN_EN
    compared++; if (bomb_blast !== 4'b0011 || blast_pulse !== 1'b1 || blast_slot !== 3'd1) begin mismatched++; $display("FAIL chain_next got=%b/%b/%0d exp=0011/1/1", bomb_blast, blast_pulse, blast_slot); end
`else
    compared++; if (bomb_blast !== 4'b0001 || blast_pulse !== 1'b0) begin mismatched++; $display("FAIL chain_indep got=%b/%b exp=0001/0", bomb_blast, blast_pulse); end
`endif
    repeat (4) cyc(1);
    compared++; if (bomb_blast !== 4'b0011) begin mismatched++; $display("FAIL chain_own got=%b exp=0011", bomb_blast); end
  endtask
  task automatic test_random;
    logic [NS-1:0] ef, eb;
    logic [3:0] got, exp;
    logic [9:0] rx, ry;
    int ent, live, s, p, n;
    restart;
    for (int i = 0; i < NS; i++) used[i] = 0;
    for (int k = 0; k < 60; k++) begin
      n = $urandom_range(0, 25);
      for (int t = 0; t < n; t++) begin
        ent = -1;
        for (int i = NS - 1; i >= 0; i--) if (used[i] && gt - placed[i] == FT - 1) ent = i;
        cyc(1);
        for (int i = 0; i < NS; i++) begin ef[i] = mstate(i) == 1; eb[i] = mstate(i) == 2; end
        compared++; if ({bomb_fuse, bomb_blast} !== {ef, eb}) begin mismatched++; $display("FAIL rnd_state k=%0d got=%b exp=%b", k, {bomb_fuse, bomb_blast}, {ef, eb}); end
        compared++; if (blast_pulse !== (ent >= 0)) begin mismatched++; $display("FAIL rnd_pulse k=%0d got=%b exp=%b", k, blast_pulse, ent >= 0); end
        if (ent >= 0) begin
          compared++; if (blast_slot !== 3'(ent)) begin mismatched++; $display("FAIL rnd_bslot k=%0d got=%0d exp=%0d", k, blast_slot, ent); end
        end
      end
      p = $urandom_range(1, 2);
      rx = 10'(k * 16 + $urandom_range(0, 15));
      ry = 10'(k * 16 + $urandom_range(0, 15));
      live = 0;
      s = -1;
      for (int i = NS - 1; i >= 0; i--) begin
        if (mstate(i) == 0) s = i;
        else if (owner_m[i] == p) live++;
      end
      request(p, rx, ry);
      got = {p1_ack, p1_nack, p2_ack, p2_nack};
      exp = (s >= 0 && live < MP) ? 4'b1000 : 4'b0100;
      if (p == 2) exp = exp >> 2;
      compared++; if (got !== exp) begin mismatched++; $display("FAIL rnd_resp k=%0d p=%0d got=%b exp=%b", k, p, got, exp); end
      if (exp[3] || exp[1]) begin
        compared++; if (bomb_x[s*10 +: 10] !== rx || bomb_y[s*10 +: 10] !== ry || bomb_owner[s] !== (p == 2)) begin mismatched++; $display("FAIL rnd_slot k=%0d s=%0d got=%0d,%0d,%b exp=%0d,%0d,%b", k, s, bomb_x[s*10 +: 10], bomb_y[s*10 +: 10], bomb_owner[s], rx, ry, p == 2); end
        used[s] = 1;
        placed[s] = gt;
        owner_m[s] = p;
      end
    end
  endtask
  initial begin
    test_reset;
    test_single;
    test_contention;
    test_limit;
    test_free_same_cycle;
    test_restart;
    test_chain;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
